// File: rtl/ap_job_sequencer.sv
// ap_job_sequencer: runs one AP job end to end: load columns A/B, compute under a timeout, drain column C.
module ap_job_sequencer #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int ADDR_W     = 9,
    parameter int READ_LAT   = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 clka,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [2:0]           job_cmd_i,
    input  logic [ADDR_W:0]      job_len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_err_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WORD_SIZE-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WORD_SIZE-1:0] out_data_o,
    output logic                 out_last_o,
    output logic [ADDR_W-1:0]    ap_addr_o,
    output logic [WORD_SIZE-1:0] ap_data_in_o,
    output logic                 ap_write_en_o,
    output logic                 ap_read_en_o,
    output logic [1:0]           ap_sel_col_o,
    output logic                 ap_mode_o,
    output logic [2:0]           ap_cmd_o,
    input  logic [WORD_SIZE-1:0] ap_data_out_i,
    input  logic                 ap_irq_i
);
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, WAIT_IRQ, SETTLE, DRAIN} state_t;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int LW = $clog2(READ_LAT + 1) + 1;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(CELL_QUANT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(READ_LAT);
    state_t st_q;
    logic ph_q, rd_pend_q, busy_q, done_q, err_q, out_valid_q, out_last_q, we_q, re_q, mode_q;
    logic [ADDR_W:0] addr_q, len_q;
    logic [TW-1:0] tmo_q;
    logic [LW-1:0] lat_q;
    logic [WORD_SIZE-1:0] out_data_q, wdata_q;
    logic [ADDR_W-1:0] ap_addr_q;
    logic [1:0] sel_q;
    logic [2:0] cmd_q;
    logic len_ok, addr_last;
    assign len_ok = job_len_i != '0 && job_len_i <= MAX_LEN;
    assign addr_last = addr_q == len_q - 1'b1;
    assign in_ready_o = (st_q == LOAD_A || st_q == LOAD_B) && !ph_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign timeout_err_o = err_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o = out_data_q;
    assign out_last_o = out_last_q;
    assign ap_addr_o = ap_addr_q;
    assign ap_data_in_o = wdata_q;
    assign ap_write_en_o = we_q;
    assign ap_read_en_o = re_q;
    assign ap_sel_col_o = sel_q;
    assign ap_mode_o = mode_q;
    assign ap_cmd_o = cmd_q;
    always_ff @(posedge clka) begin
        if (rst) begin
            st_q <= IDLE;
            {ph_q, rd_pend_q, busy_q, done_q, err_q, out_valid_q, out_last_q, we_q, re_q, mode_q} <= '0;
            addr_q <= '0;
            len_q <= '0;
            tmo_q <= '0;
            lat_q <= '0;
            out_data_q <= '0;
            wdata_q <= '0;
            ap_addr_q <= '0;
            sel_q <= '0;
            cmd_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q <= 1'b0;
            we_q <= 1'b0;
            re_q <= 1'b0;
            case (st_q)
                IDLE: if (start_i) begin
                    if (len_ok) begin
                        st_q <= LOAD_A;
                        len_q <= job_len_i;
                        cmd_q <= job_cmd_i;
                        addr_q <= '0;
                        ph_q <= 1'b0;
                        busy_q <= 1'b1;
                    end else err_q <= 1'b1;
                end
                LOAD_A, LOAD_B: if (!ph_q) begin
                    if (in_valid_i) begin
                        wdata_q <= in_data_i;
                        ap_addr_q <= addr_q[ADDR_W-1:0];
                        sel_q <= st_q == LOAD_B ? 2'd1 : 2'd0;
                        we_q <= 1'b1;
                        ph_q <= 1'b1;
                    end
                end else begin
                    ph_q <= 1'b0;
                    addr_q <= addr_last ? '0 : addr_q + 1'b1;
                    if (addr_last) st_q <= st_q == LOAD_A ? LOAD_B : COMPUTE;
                end
                COMPUTE: begin
                    mode_q <= 1'b1;
                    tmo_q <= '0;
                    st_q <= WAIT_IRQ;
                end
                // irq is checked first so it wins when it lands on the final timeout cycle
                WAIT_IRQ: if (ap_irq_i) begin
                    mode_q <= 1'b0;
                    st_q <= SETTLE;
                end else if (tmo_q == TMO_LAST) begin
                    mode_q <= 1'b0;
                    err_q <= 1'b1;
                    busy_q <= 1'b0;
                    st_q <= IDLE;
                end else tmo_q <= tmo_q + 1'b1;
                SETTLE: st_q <= DRAIN;
                DRAIN: if (out_valid_q) begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_last_q <= 1'b0;
                        addr_q <= out_last_q ? '0 : addr_q + 1'b1;
                        if (out_last_q) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            st_q <= IDLE;
                        end
                    end
                end else if (!rd_pend_q) begin
                    re_q <= 1'b1;
                    ap_addr_q <= addr_q[ADDR_W-1:0];
                    sel_q <= 2'd2;
                    rd_pend_q <= 1'b1;
                    lat_q <= '0;
                end else if (lat_q == LAT_LAST) begin
                    out_data_q <= ap_data_out_i;
                    out_valid_q <= 1'b1;
                    out_last_q <= addr_last;
                    rd_pend_q <= 1'b0;
                end else lat_q <= lat_q + 1'b1;
                default: st_q <= IDLE;
            endcase
        end
    end
endmodule
